sprite_mem_loader: RTL and testbench
====================================

// Module: sprite_mem_loader
// PURPOSE
//  Writer side of the palette-indexed sprite memories. Receives a byte stream (UART/host
//  loader) carrying a header, palette entries and per-pixel palette indices, and drives the
//  write ports of the image BRAM (8-bit index/pixel) and palette BRAM (24-bit RGB).
//  Sits between the byte source and port A of both BRAMs; sprite readers use them afterwards.
// PARAMETERS
//  WIDTH      256    sprite width in pixels
//  HEIGHT     256    sprite height in pixels
//  MAGIC      8'hA5  frame start byte
//  IMG_AW     $clog2(WIDTH*HEIGHT)  localparam, image address width
// PORTS
//  pixel_clk_in    in   1       single clock; all logic on rising edge
//  rst_in          in   1       synchronous reset, active-high
//  byte_in         in   8       stream data
//  byte_valid_in   in   1       byte_in valid; byte accepted when valid && ready
//  byte_ready_out  out  1       loader can accept a byte this cycle
//  pal_addr_out    out  8       palette BRAM write address
//  pal_data_out    out  24      {R,G,B} to palette BRAM
//  pal_we_out      out  1       palette write enable, 1-cycle pulse per entry
//  img_addr_out    out  IMG_AW  image BRAM write address
//  img_data_out    out  8       palette index to image BRAM
//  img_we_out      out  1       image write enable, 1-cycle pulse per pixel
//  busy_out        out  1       high from accepted MAGIC until DONE
//  done_out        out  1       1-cycle pulse after last pixel written
//  error_out       out  1       sticky; cleared on next accepted MAGIC
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except byte_ready_out=1; counters 0. Reset mid-frame
//    aborts: no further writes, partial BRAM contents left as-is.
//  - Frame: MAGIC, N (palette count, 0 means 256), 3*N bytes R,G,B, WIDTH*HEIGHT index bytes.
//  - FSM: IDLE -(MAGIC)-> COUNT -> PAL -> IMG -> DONE -> IDLE.
//    IDLE: non-MAGIC byte discarded, sets error_out. MAGIC clears error_out, sets busy_out.
//    COUNT: latch N (9-bit, 0->256); pal entry counter=0, byte phase=0.
//    PAL: phase 0/1/2 captures R/G/B; on B accept, next cycle pal_we_out=1,
//      pal_addr_out=entry, pal_data_out={R,G,B}; after entry N-1 -> IMG, pixel counter=0.
//    IMG: each accepted byte -> next cycle img_we_out=1, img_addr_out=pixel count,
//      img_data_out=byte; byte >= N (N<256) sets error_out but is still written.
//      After pixel WIDTH*HEIGHT-1 -> DONE.
//    DONE: one cycle; byte_ready_out=0, done_out=1, busy_out=0 next cycle; then IDLE.
//  - Latency: write strobe exactly 1 cycle after the accepting edge; no write coalescing.
//  - byte_ready_out=1 in every state except DONE; bytes with valid low are ignored.
//  - Counters never wrap: pixel counter stops at WIDTH*HEIGHT-1, addresses stay in range.
//  - MAGIC inside PAL/IMG is data, not a restart (only rst_in aborts a frame).
//  - pal_we_out and img_we_out never high in the same cycle.
// STRUCTURE
//  - sprite_pkg: loader_state_t enum {IDLE,COUNT,PAL,IMG,DONE}, SPRITE_MAGIC constant,
//    rgb24_t packed struct {r,g,b}.
//  - Sub-module rgb_byte_packer: 3-phase byte-to-rgb24_t assembler with phase counter,
//    clear input and 1-cycle entry_valid output; FSM, counters, strobes stay in the top.
// TESTING (bench models both BRAMs as arrays, compares against expected contents)
//  1 WIDTH=4,HEIGHT=2: A5,02,FF,00,00,00,FF,00,then 01,00,01,00,01,00,01,00 -> pal[0]=FF0000,
//    pal[1]=00FF00, img[0..7]=1,0,1,0,1,0,1,0; done_out one pulse; error_out=0.
//  2 Bytes 3C,A5 in IDLE -> 3C discarded, error_out=1; accepting A5 clears error_out, busy_out=1.
//  3 N=00 -> 256 palette entries written, pal_addr_out 0..255, then IMG entered.
//  4 N=02, pixel byte 07 -> img written with 07, error_out=1 sticky through done_out.
//  5 Random byte_valid_in gaps (~50%) -> identical BRAM contents to case 1; one we per entry.
//  6 rst_in asserted after 3rd pixel -> next cycle all strobes 0, state IDLE, busy_out=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite memory loader.
package sprite_pkg;

    // Frame-parsing states of the loader FSM
    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        PAL,
        IMG,
        DONE
    } loader_state_t;

    // Byte that opens every frame
    localparam logic [7:0] SPRITE_MAGIC = 8'hA5;

    // One palette entry as stored in the palette BRAM
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

endpackage

// File: rtl/rgb_byte_packer.sv
// Assembles three consecutive bytes (R, G, B) into one rgb24_t palette entry.
// The entry and its valid pulse appear the cycle after the B byte is taken.
module rgb_byte_packer
    import sprite_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic [7:0] i_byte,
    input  logic       i_byte_en,
    output logic       o_last,
    output rgb24_t     o_rgb,
    output logic       o_entry_valid
);

    logic [1:0] r_phase;
    logic [7:0] r_r;
    logic [7:0] r_g;

    // Next accepted byte completes an entry
    assign o_last = (r_phase == 2'd2);

    // Phase counter and R/G holding registers; B completes the entry
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase       <= 2'd0;
            r_r           <= 8'd0;
            r_g           <= 8'd0;
            o_rgb         <= '0;
            o_entry_valid <= 1'b0;
        end else begin
            o_entry_valid <= 1'b0;
            if (i_clr) begin
                r_phase <= 2'd0;
            end else if (i_byte_en) begin
                case (r_phase)
                    2'd0: begin
                        r_r     <= i_byte;
                        r_phase <= 2'd1;
                    end
                    2'd1: begin
                        r_g     <= i_byte;
                        r_phase <= 2'd2;
                    end
                    default: begin
                        o_rgb         <= '{r: r_r, g: r_g, b: i_byte};
                        o_entry_valid <= 1'b1;
                        r_phase       <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/sprite_mem_loader.sv
// Byte-stream loader for the palette and image BRAMs of a palette-indexed sprite.
// Frame: MAGIC, N (0 = 256), 3*N palette bytes, WIDTH*HEIGHT index bytes.
// Every write strobe is registered and fires exactly one cycle after its byte is taken.
module sprite_mem_loader
    import sprite_pkg::*;
#(
    parameter  int         WIDTH  = 256,
    parameter  int         HEIGHT = 256,
    parameter  logic [7:0] MAGIC  = SPRITE_MAGIC,
    localparam int         IMG_AW = $clog2(WIDTH*HEIGHT)
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid_in,
    output logic              byte_ready_out,
    output logic [7:0]        pal_addr_out,
    output logic [23:0]       pal_data_out,
    output logic              pal_we_out,
    output logic [IMG_AW-1:0] img_addr_out,
    output logic [7:0]        img_data_out,
    output logic              img_we_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out
);

    localparam logic [IMG_AW-1:0] LAST_PIX = IMG_AW'(WIDTH*HEIGHT - 1);

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic              w_acc;
    logic              w_pk_en;
    logic              w_pk_clr;
    logic              w_pk_last;
    logic              w_pal_last;
    rgb24_t            w_rgb;

    logic [8:0]        r_n;
    logic [8:0]        r_entry;
    logic [IMG_AW-1:0] r_pix;
    logic [7:0]        r_pal_addr;
    logic [IMG_AW-1:0] r_img_addr;
    logic [7:0]        r_img_data;
    logic              r_img_we;
    logic              r_busy;
    logic              r_err;

    // Only the single DONE cycle stalls the source
    assign byte_ready_out = (r_state != DONE);
    assign w_acc          = byte_valid_in && (r_state != DONE);
    assign w_pal_last     = (r_entry == r_n - 9'd1);

    assign pal_addr_out   = r_pal_addr;
    assign pal_data_out   = w_rgb;
    assign img_addr_out   = r_img_addr;
    assign img_data_out   = r_img_data;
    assign img_we_out     = r_img_we;
    assign busy_out       = r_busy;
    assign error_out      = r_err;

    rgb_byte_packer u_packer (
        .i_clk         (pixel_clk_in),
        .i_rst         (rst_in),
        .i_clr         (w_pk_clr),
        .i_byte        (byte_in),
        .i_byte_en     (w_pk_en),
        .o_last        (w_pk_last),
        .o_rgb         (w_rgb),
        .o_entry_valid (pal_we_out)
    );

    // State register
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode plus packer control and the done pulse
    always_comb begin
        w_next   = r_state;
        w_pk_en  = 1'b0;
        w_pk_clr = 1'b0;
        done_out = 1'b0;
        case (r_state)
            IDLE:  if (w_acc && byte_in == MAGIC) w_next = COUNT;
            COUNT: if (w_acc) begin
                       w_pk_clr = 1'b1;
                       w_next   = PAL;
                   end
            PAL:   begin
                       w_pk_en = w_acc;
                       if (w_acc && w_pk_last && w_pal_last) w_next = IMG;
                   end
            IMG:   if (w_acc && r_pix == LAST_PIX) w_next = DONE;
            DONE:  begin
                       done_out = 1'b1;
                       w_next   = IDLE;
                   end
            default: w_next = IDLE;
        endcase
    end

    // Counters, image write strobe, busy and sticky error
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_n        <= 9'd0;
            r_entry    <= 9'd0;
            r_pix      <= '0;
            r_pal_addr <= 8'd0;
            r_img_addr <= '0;
            r_img_data <= 8'd0;
            r_img_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_img_we <= 1'b0;
            case (r_state)
                IDLE: if (w_acc) begin
                    if (byte_in == MAGIC) begin
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                    end else begin
                        r_err  <= 1'b1;
                    end
                end
                COUNT: if (w_acc) begin
                    r_n     <= (byte_in == 8'd0) ? 9'd256 : {1'b0, byte_in};
                    r_entry <= 9'd0;
                end
                PAL: if (w_acc && w_pk_last) begin
                    r_pal_addr <= r_entry[7:0];
                    if (w_pal_last) r_pix   <= '0;
                    else            r_entry <= r_entry + 9'd1;
                end
                IMG: if (w_acc) begin
                    r_img_we   <= 1'b1;
                    r_img_addr <= r_pix;
                    r_img_data <= byte_in;
                    // With N = 256 every index is legal, so the 9-bit compare never fires
                    if ({1'b0, byte_in} >= r_n) r_err <= 1'b1;
                    if (r_pix != LAST_PIX) r_pix <= r_pix + 1'b1;
                end
                DONE: r_busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_mem_loader.sv
// Scoreboard bench for sprite_mem_loader on a 4x2 sprite.
module tb_sprite_mem_loader;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;
    localparam int AW   = $clog2(NPIX);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    bin = 8'd0;
    logic          bval = 1'b0;
    logic          rdy;
    logic [7:0]    pal_addr;
    logic [23:0]   pal_data;
    logic          pal_we;
    logic [AW-1:0] img_addr;
    logic [7:0]    img_data;
    logic          img_we;
    logic          busy;
    logic          done;
    logic          err;

    sprite_mem_loader #(.WIDTH(W), .HEIGHT(H)) dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst),
        .byte_in        (bin),
        .byte_valid_in  (bval),
        .byte_ready_out (rdy),
        .pal_addr_out   (pal_addr),
        .pal_data_out   (pal_data),
        .pal_we_out     (pal_we),
        .img_addr_out   (img_addr),
        .img_data_out   (img_data),
        .img_we_out     (img_we),
        .busy_out       (busy),
        .done_out       (done),
        .error_out      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [23:0] data;
    } wr_t;

    wr_t         pal_q[$];
    wr_t         img_q[$];
    logic [23:0] pal_mem [0:255];
    logic [7:0]  img_mem [0:NPIX-1];
    int          n_checks   = 0;
    int          n_errs     = 0;
    int          gap_pct    = 0;
    int          exp_pix    = 0;
    int          done_cnt   = 0;
    int          pal_we_cnt = 0;
    int          img_we_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) pal_mem[i] = 24'd0;
        for (int i = 0; i < NPIX; i++) img_mem[i] = 8'd0;
        done_cnt   = 0;
        pal_we_cnt = 0;
        img_we_cnt = 0;
    endtask

    // Presents one byte; returns 1 ns after the accepting edge
    task automatic send(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) @(negedge clk);
        while (!rdy && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (!rdy) chk("ready_timeout", 32'd0, 32'd1);
        bin  = b;
        bval = 1'b1;
        @(posedge clk);
        #1 bval = 1'b0;
    endtask

    task automatic send_pal(input int idx, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
        send(r);
        send(g);
        pal_q.push_back('{addr: idx, data: {r, g, b}});
        send(b);
    endtask

    task automatic send_pix(input logic [7:0] b);
        img_q.push_back('{addr: exp_pix, data: {16'd0, b}});
        exp_pix++;
        send(b);
    endtask

    task automatic start_frame(input logic [7:0] n);
        send(8'hA5);
        send(n);
        exp_pix = 0;
    endtask

    // Called right after the last pixel is accepted: DONE cycle, then idle
    task automatic finish_frame(input string tag, input logic exp_err);
        chk({tag, "_done_hi"}, done, 1);
        chk({tag, "_ready_lo"}, rdy, 0);
        @(posedge clk);
        #1;
        chk({tag, "_done_lo"}, done, 0);
        chk({tag, "_busy_lo"}, busy, 0);
        chk({tag, "_ready_hi"}, rdy, 1);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_palq_empty"}, pal_q.size(), 0);
        chk({tag, "_imgq_empty"}, img_q.size(), 0);
    endtask

    task automatic run_case1(input string tag);
        start_frame(8'h02);
        chk({tag, "_busy_after_magic"}, busy, 1);
        send_pal(0, 8'hFF, 8'h00, 8'h00);
        send_pal(1, 8'h00, 8'hFF, 8'h00);
        for (int i = 0; i < NPIX; i++) send_pix((i % 2 == 0) ? 8'h01 : 8'h00);
        finish_frame(tag, 1'b0);
        chk({tag, "_pal0"}, pal_mem[0], 24'hFF0000);
        chk({tag, "_pal1"}, pal_mem[1], 24'h00FF00);
        for (int i = 0; i < NPIX; i++)
            chk({tag, "_img"}, img_mem[i], (i % 2 == 0) ? 8'h01 : 8'h00);
        chk({tag, "_pal_we_cnt"}, pal_we_cnt, 2);
        chk({tag, "_img_we_cnt"}, img_we_cnt, NPIX);
        chk({tag, "_done_cnt"}, done_cnt, 1);
    endtask

    // Monitor: pops expected writes whenever the DUT strobes a BRAM port
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("we_exclusive", {31'd0, pal_we & img_we}, 0);
                if (pal_we) begin
                    pal_we_cnt++;
                    if (pal_q.size() == 0) chk("pal_unexpected", 1, 0);
                    else begin
                        e = pal_q.pop_front();
                        chk("pal_addr", pal_addr, e.addr);
                        chk("pal_data", pal_data, e.data);
                    end
                    pal_mem[pal_addr] = pal_data;
                end
                if (img_we) begin
                    img_we_cnt++;
                    if (img_q.size() == 0) chk("img_unexpected", 1, 0);
                    else begin
                        e = img_q.pop_front();
                        chk("img_addr", img_addr, e.addr);
                        chk("img_data", img_data, e.data);
                    end
                    img_mem[img_addr] = img_data;
                end
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_pal_we", pal_we, 0);
        chk("rst_img_we", img_we, 0);
        chk("rst_pal_addr", pal_addr, 0);
        chk("rst_img_addr", img_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: basic frame, two palette entries, checkerboard indices
        run_case1("c1");

        // 2: stray byte in IDLE flags error; MAGIC clears it
        clear_model();
        send(8'h3C);
        chk("c2_err_set", err, 1);
        chk("c2_busy_idle", busy, 0);
        send(8'hA5);
        chk("c2_err_clr", err, 0);
        chk("c2_busy_set", busy, 1);
        send(8'h01);
        exp_pix = 0;
        send_pal(0, 8'h10, 8'h20, 8'h30);
        for (int i = 0; i < NPIX; i++) send_pix(8'h00);
        finish_frame("c2", 1'b0);
        chk("c2_pal0", pal_mem[0], 24'h102030);

        // 3: N=0 means 256 entries; MAGIC byte inside PAL/IMG is plain data
        clear_model();
        start_frame(8'h00);
        for (int i = 0; i < 256; i++)
            send_pal(i, 8'(i), ~8'(i), 8'(i) ^ 8'h55);
        for (int i = 0; i < NPIX; i++) send_pix((i == 2) ? 8'hA5 : 8'(i * 37));
        finish_frame("c3", 1'b0);
        chk("c3_pal_we_cnt", pal_we_cnt, 256);
        chk("c3_pal0", pal_mem[0], 24'h00FF55);
        chk("c3_pal255", pal_mem[255], 24'hFF00AA);
        chk("c3_img2", img_mem[2], 8'hA5);
        chk("c3_img7", img_mem[7], 8'h03);

        // 4: index out of palette range is written and sets a sticky error
        clear_model();
        start_frame(8'h02);
        send_pal(0, 8'h01, 8'h02, 8'h03);
        send_pal(1, 8'h04, 8'h05, 8'h06);
        send_pix(8'h00);
        chk("c4_err_before", err, 0);
        send_pix(8'h07);
        chk("c4_err_set", err, 1);
        for (int i = 2; i < NPIX; i++) send_pix(8'h01);
        chk("c4_err_at_done", err, 1);
        finish_frame("c4", 1'b1);
        chk("c4_img1", img_mem[1], 8'h07);

        // 5: same frame as case 1 with random valid gaps
        clear_model();
        gap_pct = 50;
        run_case1("c5");
        gap_pct = 0;

        // 6: reset after the third pixel aborts the frame
        clear_model();
        start_frame(8'h02);
        send_pal(0, 8'hAA, 8'hBB, 8'hCC);
        send_pal(1, 8'h11, 8'h22, 8'h33);
        send_pix(8'h01);
        send_pix(8'h00);
        send_pix(8'h01);
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("c6_pal_we", pal_we, 0);
        chk("c6_img_we", img_we, 0);
        chk("c6_busy", busy, 0);
        chk("c6_done", done, 0);
        chk("c6_ready", rdy, 1);
        chk("c6_imgq_empty", img_q.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("c6_no_more_writes", img_we_cnt, 3);
        send(8'h00);
        chk("c6_idle_err", err, 1);
        chk("c6_idle_busy", busy, 0);
        chk("c6_img_we_cnt", img_we_cnt, 3);
        chk("c6_img2", img_mem[2], 8'h01);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
